// File: rtl/cordic_deformat_clocked.sv
// Output-side CORDIC deformatter: removes the CORDIC gain, restores quadrant signs,
// and presents pdQp samples through a 3-stage elastic valid/ready pipeline.
module cordic_deformat_clocked #(
  parameter int pd = 4,
  parameter int p  = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [pd+p-1:0]     cos_in,
  input  logic [pd+p-1:0]     sin_in,
  input  logic                flip_cos,
  input  logic                flip_sin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [pd+p-1:0]     cos_out,
  output logic [pd+p-1:0]     sin_out
);

  localparam int W  = pd + p;
  localparam int W2 = 2 * W;

  // 1/K held as 8Q22, rounded to nearest at bit 22-p to get the pdQp multiplier
  localparam logic [29:0] KINV_Q22 = 30'd2547003;
  localparam logic [29:0] KINV_RND = (KINV_Q22 + (30'd1 << (21 - p))) >> (22 - p);
  localparam logic signed [W2-1:0] KINV_P = W2'(KINV_RND);

  localparam int MAX_I = (2 ** (W - 1)) - 1;
  localparam logic signed [W2-1:0] SAT_MAX = W2'(MAX_I);
  localparam logic signed [W2-1:0] SAT_MIN = W2'(-MAX_I - 1);
  localparam logic signed [W2-1:0] HALF    = W2'(2 ** (p - 1));

  localparam logic [W-1:0] MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};

  function automatic logic [W-1:0] scale(input logic [W-1:0] v);
    logic signed [W2-1:0] ext;
    logic signed [W2-1:0] acc;
    ext = $signed({{W{v[W-1]}}, v});
    acc = (ext * KINV_P) + HALF;
    acc = acc >>> p;
    if (acc > SAT_MAX) begin
      return MAX_W;
    end else if (acc < SAT_MIN) begin
      return MIN_W;
    end
    return acc[W-1:0];
  endfunction

  function automatic logic [W-1:0] negate_sat(input logic [W-1:0] v);
    if (v == MIN_W) begin
      return MAX_W;
    end
    return -v;
  endfunction

  logic         s1_valid, s2_valid, s3_valid;
  logic         s1_ready, s2_ready, s3_ready;
  logic [W-1:0] s1_cos, s1_sin;
  logic         s1_fc, s1_fs;
  logic [W-1:0] s2_cos, s2_sin;
  logic         s2_fc, s2_fs;
  logic [W-1:0] s3_cos, s3_sin;
  logic [W-1:0] s2_cos_next, s2_sin_next;
  logic [W-1:0] s3_cos_next, s3_sin_next;

  // A stage can take new data when it is empty or its contents move on this cycle
  always_comb begin
    s3_ready = !s3_valid || out_ready;
    s2_ready = !s2_valid || s3_ready;
    s1_ready = !s1_valid || s2_ready;
  end

  always_comb begin
    s2_cos_next = scale(s1_cos);
    s2_sin_next = scale(s1_sin);
    s3_cos_next = s2_fc ? negate_sat(s2_cos) : s2_cos;
    s3_sin_next = s2_fs ? negate_sat(s2_sin) : s2_sin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cos   <= '0;
      s1_sin   <= '0;
      s1_fc    <= 1'b0;
      s1_fs    <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cos <= cos_in;
        s1_sin <= sin_in;
        s1_fc  <= flip_cos;
        s1_fs  <= flip_sin;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_cos   <= '0;
      s2_sin   <= '0;
      s2_fc    <= 1'b0;
      s2_fs    <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_cos <= s2_cos_next;
        s2_sin <= s2_sin_next;
        s2_fc  <= s1_fc;
        s2_fs  <= s1_fs;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_cos   <= '0;
      s3_sin   <= '0;
    end else if (s3_ready) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_cos <= s3_cos_next;
        s3_sin <= s3_sin_next;
      end
    end
  end

  assign in_ready  = s1_ready;
  assign out_valid = s3_valid;
  assign cos_out   = s3_cos;
  assign sin_out   = s3_sin;

endmodule

// File: tb/tb_cordic_deformat_clocked.sv
// Bench for cordic_deformat_clocked: real-arithmetic reference model with a scoreboard
// checked on every output transfer, plus directed literal expectations.
module tb_cordic_deformat_clocked;

  localparam int W = 13;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] cos_in = '0;
  logic [W-1:0] sin_in = '0;
  logic         flip_cos = 1'b0;
  logic         flip_sin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] cos_out;
  logic [W-1:0] sin_out;

  cordic_deformat_clocked #(.pd(4), .p(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .cos_in(cos_in), .sin_in(sin_in),
    .flip_cos(flip_cos), .flip_sin(flip_sin),
    .out_valid(out_valid), .out_ready(out_ready),
    .cos_out(cos_out), .sin_out(sin_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int outs = 0;

  typedef struct { int c; int s; } exp_t;
  exp_t q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int clamp(input int v);
    if (v > 4095) return 4095;
    if (v < -4096) return -4096;
    return v;
  endfunction

  // Gain removal with 1/K quantised to 311/512, rounded half toward +inf
  function automatic int model(input int v, input bit flip);
    real t;
    int r;
    t = $floor(real'(v) * 311.0 / 512.0 + 0.5);
    r = clamp($rtoi(t));
    if (flip) r = clamp(-r);
    return r;
  endfunction

  task automatic set_in(input bit v, input int c, input int s, input bit fc, input bit fs);
    in_valid = v;
    cos_in   = W'(c);
    sin_in   = W'(s);
    flip_cos = fc;
    flip_sin = fs;
  endtask

  // Scoreboard monitor, sampled mid-cycle once inputs have settled
  logic         hold_pending = 1'b0;
  logic [W-1:0] prev_cos, prev_sin;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_cos", sx(cos_out), sx(prev_cos));
        check("hold_sin", sx(sin_out), sx(prev_sin));
      end
      if (out_valid && out_ready) begin
        outs++;
        check("queue_nonempty", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("sb_cos", sx(cos_out), e.c);
          check("sb_sin", sx(sin_out), e.s);
        end
      end
      hold_pending = out_valid && !out_ready;
      prev_cos = cos_out;
      prev_sin = sin_out;
      if (in_valid && in_ready) begin
        accepts++;
        e.c = model(sx(cos_in), flip_cos);
        e.s = model(sx(sin_in), flip_sin);
        q.push_back(e);
      end
    end
  end

  task automatic run_single(input int c, input int s, input bit fc, input bit fs,
                            input int exp_c, input int exp_s);
    int n;
    check("model_cos", model(c, fc), exp_c);
    check("model_sin", model(s, fs), exp_s);
    @(posedge clk); #1;
    set_in(1'b1, c, s, fc, fs);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 3);
    check("lit_cos", sx(cos_out), exp_c);
    check("lit_sin", sx(sin_out), exp_s);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ones, first, last, acc0, outs0;
    int tc[8] = '{843, -843, 1, -1, 4095, -4096, 100, 0};
    int ts[8] = '{0, 843, -1, 1, -4096, 4095, -100, 7};

    // Reset asserted before any clock edge must clear outputs asynchronously
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_cos_out", sx(cos_out), 0);
    check("rst_sin_out", sx(sin_out), 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 1);

    // Directed single samples, out_ready held high
    out_ready = 1'b1;
    run_single(843, 0, 1'b0, 1'b0, 512, 0);
    run_single(843, 0, 1'b1, 1'b0, -512, 0);
    run_single(1, -4096, 1'b0, 1'b1, 1, 2488);
    run_single(-1, 4095, 1'b0, 1'b0, -1, 2487);

    // Streaming: 8 back-to-back samples, outputs must be 8 consecutive cycles
    ones = 0; first = -1; last = -1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        ones++;
        if (first < 0) first = i;
        last = i;
      end
      if (i < 8) set_in(1'b1, tc[i], ts[i], i[0], i[1]);
      else in_valid = 1'b0;
    end
    check("stream_count", ones, 8);
    check("stream_contig", last - first + 1, 8);
    check("stream_first", first, 3);

    // Backpressure: only three samples fit while the consumer stalls
    acc0 = accepts;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      set_in(1'b1, 200 * i - 333, 4000 - 1500 * i, i[0], !i[0]);
    end
    @(posedge clk); #1;
    check("bp_accepted", accepts - acc0, 3);
    check("bp_in_ready", int'(in_ready), 0);
    check("bp_out_valid", int'(out_valid), 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("bp_drained", q.size(), 0);

    // Random handshakes against the scoreboard
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      set_in($urandom_range(0, 3) != 0,
             int'($urandom_range(0, 8191)) - 4096,
             int'($urandom_range(0, 8191)) - 4096,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      out_ready = $urandom_range(0, 2) != 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rand_drained", q.size(), 0);

    // Reset with two samples in flight: neither may emerge
    @(posedge clk); #1;
    set_in(1'b1, 843, 843, 1'b0, 1'b0);
    @(posedge clk); #1;
    set_in(1'b1, -843, 1, 1'b1, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_cos_out", sx(cos_out), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    outs0 = outs;
    run_single(-843, -843, 1'b1, 1'b1, 512, 512);
    repeat (4) @(posedge clk);
    #1;
    check("midrst_outputs", outs - outs0, 1);
    check("midrst_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
